// File: rtl/uart_rx_pkg.sv
// Shared constants and types for the uart_rx_mon receiver and its FIFO.
package uart_rx_pkg;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StWaitHigh
    } rx_state_e;

    // FIFO entry layout: {data, frame error, parity error, break}
    function automatic int unsigned entry_width(input int unsigned data_bits);
        return data_bits + 3;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous show-ahead FIFO; extra pointer bit separates full from empty.
module uart_rx_fifo #(
    parameter int unsigned WIDTH = 11,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             overflow
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;

    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop    = !w_empty && rd_ready;
    // A pop in the same cycle frees the slot the write lands in.
    assign w_push   = wr_en && (!w_full || w_pop);
    assign overflow = wr_en && w_full && !w_pop;

    assign rd_valid = !w_empty;
    assign rd_data  = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
                r_wr_ptr                <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx_mon.sv
// UART receiver/monitor: mid-bit sampling, runtime divider, framing/parity/break
// flags, and a small receive FIFO behind a valid/ready read port.
module uart_rx_mon
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned DIV_WIDTH  = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [DIV_WIDTH-1:0] cfg_div,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 rd_err_frame,
    output logic                 rd_err_parity,
    output logic                 rd_break,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic                 overflow,
    output logic                 busy
);

    localparam int unsigned ENTRY_W = entry_width(DATA_BITS);

    logic                 r_rx_meta;
    logic                 r_rxs;
    logic                 r_rxs_prev;

    rx_state_e            r_state,    w_state_next;
    logic [DIV_WIDTH-1:0] r_cnt,      w_cnt_next;
    logic [DIV_WIDTH-1:0] r_div,      w_div_next;
    logic [3:0]           r_bit_idx,  w_bit_idx_next;
    logic                 r_stop_idx, w_stop_idx_next;
    logic [DATA_BITS-1:0] r_shift,    w_shift_next;
    logic                 r_par_bit,  w_par_bit_next;
    logic                 r_ferr,     w_ferr_next;

    logic [DIV_WIDTH-1:0] w_div_eff;
    logic                 w_cnt_zero;
    logic                 w_ferr_now;
    logic                 w_par_xor;
    logic                 w_perr;
    logic                 w_brk;
    logic                 w_push;
    logic [ENTRY_W-1:0]   w_entry;
    logic [ENTRY_W-1:0]   w_head;

    assign w_div_eff  = (cfg_div < DIV_WIDTH'(4)) ? DIV_WIDTH'(4) : cfg_div;
    assign w_cnt_zero = (r_cnt == '0);
    assign w_ferr_now = r_ferr || !r_rxs;
    assign w_par_xor  = (^r_shift) ^ r_par_bit;
    assign w_perr     = (PARITY == PAR_ODD)  ? !w_par_xor :
                        (PARITY == PAR_EVEN) ? w_par_xor  : 1'b0;
    assign w_brk      = (r_shift == '0) && ((PARITY == PAR_NONE) || !r_par_bit) && w_ferr_now;
    assign w_entry    = {r_shift, w_ferr_now, w_perr, w_brk};
    assign busy       = (r_state != StIdle);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rx_meta  <= 1'b1;
            r_rxs      <= 1'b1;
            r_rxs_prev <= 1'b1;
        end else begin
            r_rx_meta  <= rx;
            r_rxs      <= r_rx_meta;
            r_rxs_prev <= r_rxs;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_div      <= '0;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_shift    <= '0;
            r_par_bit  <= 1'b0;
            r_ferr     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_div      <= w_div_next;
            r_bit_idx  <= w_bit_idx_next;
            r_stop_idx <= w_stop_idx_next;
            r_shift    <= w_shift_next;
            r_par_bit  <= w_par_bit_next;
            r_ferr     <= w_ferr_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        w_div_next      = r_div;
        w_bit_idx_next  = r_bit_idx;
        w_stop_idx_next = r_stop_idx;
        w_shift_next    = r_shift;
        w_par_bit_next  = r_par_bit;
        w_ferr_next     = r_ferr;
        w_push          = 1'b0;

        case (r_state)
            StIdle: begin
                if (r_rxs_prev && !r_rxs) begin
                    w_cnt_next   = (w_div_eff >> 1) - 1'b1;
                    w_state_next = StStart;
                end
            end
            StStart: begin
                if (!w_cnt_zero) begin
                    w_cnt_next = r_cnt - 1'b1;
                end else if (r_rxs) begin
                    w_state_next = StIdle;
                end else begin
                    // Divider is frozen here for the rest of the frame.
                    w_div_next     = w_div_eff;
                    w_cnt_next     = w_div_eff - 1'b1;
                    w_bit_idx_next = '0;
                    w_par_bit_next = 1'b0;
                    w_ferr_next    = 1'b0;
                    w_state_next   = StData;
                end
            end
            StData: begin
                if (!w_cnt_zero) begin
                    w_cnt_next = r_cnt - 1'b1;
                end else begin
                    w_shift_next = {r_rxs, r_shift[DATA_BITS-1:1]};
                    w_cnt_next   = r_div - 1'b1;
                    if (r_bit_idx == 4'(DATA_BITS - 1)) begin
                        w_stop_idx_next = 1'b0;
                        w_state_next    = (PARITY != PAR_NONE) ? StParity : StStop;
                    end else begin
                        w_bit_idx_next = r_bit_idx + 1'b1;
                    end
                end
            end
            StParity: begin
                if (!w_cnt_zero) begin
                    w_cnt_next = r_cnt - 1'b1;
                end else begin
                    w_par_bit_next = r_rxs;
                    w_cnt_next     = r_div - 1'b1;
                    w_state_next   = StStop;
                end
            end
            StStop: begin
                if (!w_cnt_zero) begin
                    w_cnt_next = r_cnt - 1'b1;
                end else begin
                    w_ferr_next = w_ferr_now;
                    if (r_stop_idx == 1'(STOP_BITS - 1)) begin
                        w_push       = 1'b1;
                        w_state_next = w_ferr_now ? StWaitHigh : StIdle;
                    end else begin
                        w_stop_idx_next = 1'b1;
                        w_cnt_next      = r_div - 1'b1;
                    end
                end
            end
            StWaitHigh: begin
                if (r_rxs) begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    uart_rx_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .resetn   (resetn),
        .wr_en    (w_push),
        .wr_data  (w_entry),
        .rd_ready (rd_ready),
        .rd_data  (w_head),
        .rd_valid (rd_valid),
        .overflow (overflow)
    );

    assign rd_data       = w_head[ENTRY_W-1:3];
    assign rd_err_frame  = w_head[2];
    assign rd_err_parity = w_head[1];
    assign rd_break      = w_head[0];

endmodule

// File: tb/tb_uart_rx_mon.sv
// Directed bench: an 8N1 instance (a) and an 8E1 instance (b) on a shared clock.
module tb_uart_rx_mon;

    localparam int BIT_CYC = 106;

    logic        clk = 1'b0;
    logic        resetn;
    logic [15:0] cfg_div;
    logic        rx_a, rx_b, rdy_a, rdy_b;
    logic [7:0]  data_a, data_b;
    logic        ferr_a, perr_a, brk_a, valid_a, ovf_a, busy_a;
    logic        ferr_b, perr_b, brk_b, valid_b, ovf_b, busy_b;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int start_cyc;
    int rise_cnt_a = 0, rise_cyc_a = 0, ovf_cnt_a = 0;
    int rise_cnt_b = 0, rise_cyc_b = 0, ovf_cnt_b = 0;
    logic prev_va = 1'b0, prev_vb = 1'b0;

    always #5 clk = ~clk;

    uart_rx_mon #(
        .DATA_BITS (8), .PARITY (0), .STOP_BITS (1), .DIV_WIDTH (16), .FIFO_DEPTH (4)
    ) u_dut_a (
        .clk (clk), .resetn (resetn), .cfg_div (cfg_div), .rx (rx_a),
        .rd_data (data_a), .rd_err_frame (ferr_a), .rd_err_parity (perr_a),
        .rd_break (brk_a), .rd_valid (valid_a), .rd_ready (rdy_a),
        .overflow (ovf_a), .busy (busy_a)
    );

    uart_rx_mon #(
        .DATA_BITS (8), .PARITY (2), .STOP_BITS (1), .DIV_WIDTH (16), .FIFO_DEPTH (4)
    ) u_dut_b (
        .clk (clk), .resetn (resetn), .cfg_div (cfg_div), .rx (rx_b),
        .rd_data (data_b), .rd_err_frame (ferr_b), .rd_err_parity (perr_b),
        .rd_break (brk_b), .rd_valid (valid_b), .rd_ready (rdy_b),
        .overflow (ovf_b), .busy (busy_b)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Record rd_valid rising edges and overflow pulses, sampled mid-cycle.
    always @(negedge clk) begin
        prev_va <= valid_a;
        prev_vb <= valid_b;
        if (valid_a && !prev_va) begin
            rise_cnt_a <= rise_cnt_a + 1;
            rise_cyc_a <= cyc;
        end
        if (valid_b && !prev_vb) begin
            rise_cnt_b <= rise_cnt_b + 1;
            rise_cyc_b <= cyc;
        end
        if (ovf_a) ovf_cnt_a <= ovf_cnt_a + 1;
        if (ovf_b) ovf_cnt_b <= ovf_cnt_b + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_rx(input int sel, input logic v);
        if (sel == 0) rx_a = v;
        else rx_b = v;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Frame for instance a is 10 bits, for b 11 bits (with parity).
    task automatic send_frame(input int sel, input logic [7:0] data, input logic pbit,
                              input logic stopv, input int nbits, input bit pop_at_push);
        logic bits [0:10];
        int   total;
        total   = (sel == 1) ? 11 : 10;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1+i] = data[i];
        bits[9]  = (sel == 1) ? pbit : stopv;
        bits[10] = stopv;
        @(posedge clk);
        #1;
        start_cyc = cyc;
        for (int b = 0; b < total && b < nbits; b++) begin
            drive_rx(sel, bits[b]);
            if (pop_at_push && b == total - 1) begin
                tick(55);
                rdy_a = 1'b1;
                tick(1);
                rdy_a = 1'b0;
                tick(50);
            end else begin
                tick(BIT_CYC);
            end
        end
        if (nbits >= total) drive_rx(sel, 1'b1);
    endtask

    task automatic pop_check(input int sel, input logic [7:0] d, input logic fe,
                             input logic pe, input logic bk);
        @(negedge clk);
        if (sel == 0) begin
            check("pop_valid_a", valid_a, 1'b1);
            check("pop_entry_a", {data_a, ferr_a, perr_a, brk_a}, {d, fe, pe, bk});
            rdy_a = 1'b1;
        end else begin
            check("pop_valid_b", valid_b, 1'b1);
            check("pop_entry_b", {data_b, ferr_b, perr_b, brk_b}, {d, fe, pe, bk});
            rdy_b = 1'b1;
        end
        @(posedge clk);
        #1;
        rdy_a = 1'b0;
        rdy_b = 1'b0;
    endtask

    typedef struct {
        int         sel;
        logic [7:0] data;
        logic       pbit;
        logic       stopv;
        logic       exp_ferr;
        logic       exp_perr;
        logic       exp_brk;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int n0, o0, lat;
        logic [7:0] d;

        vecs[0] = '{0, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{0, 8'h0A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{1, 8'h03, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{1, 8'h03, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{1, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[8] = '{1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

        resetn  = 1'b0;
        cfg_div = 16'd106;
        rx_a    = 1'b1;
        rx_b    = 1'b1;
        rdy_a   = 1'b0;
        rdy_b   = 1'b0;
        #23;
        check("reset_out_a", {data_a, ferr_a, perr_a, brk_a, valid_a, ovf_a, busy_a}, 0);
        check("reset_out_b", {data_b, ferr_b, perr_b, brk_b, valid_b, ovf_b, busy_b}, 0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        tick(10);

        // Table: one frame per record, latency from start-bit drive to rd_valid rise.
        foreach (vecs[i]) begin
            n0 = (vecs[i].sel == 0) ? rise_cnt_a : rise_cnt_b;
            send_frame(vecs[i].sel, vecs[i].data, vecs[i].pbit, vecs[i].stopv, 11, 1'b0);
            tick(10);
            if (vecs[i].sel == 0) begin
                check("vec_rise_a", rise_cnt_a, n0 + 1);
                lat = rise_cyc_a - start_cyc;
                check("vec_latency_a", lat, 3 + 53 + BIT_CYC * 9);
            end else begin
                check("vec_rise_b", rise_cnt_b, n0 + 1);
                lat = rise_cyc_b - start_cyc;
                check("vec_latency_b", lat, 3 + 53 + BIT_CYC * 10);
            end
            pop_check(vecs[i].sel, vecs[i].data, vecs[i].exp_ferr, vecs[i].exp_perr,
                      vecs[i].exp_brk);
            @(negedge clk);
            check("vec_drained", {valid_a, valid_b}, 2'b00);
        end

        // False start: 20 low cycles.
        n0 = rise_cnt_a;
        @(posedge clk);
        #1;
        rx_a = 1'b0;
        tick(15);
        check("false_start_busy", busy_a, 1'b1);
        tick(5);
        rx_a = 1'b1;
        tick(100);
        check("false_start_idle", busy_a, 1'b0);
        check("false_start_empty", valid_a, 1'b0);
        check("false_start_rise", rise_cnt_a, n0);

        // Break: three character times low, one entry only.
        n0 = rise_cnt_a;
        @(posedge clk);
        #1;
        start_cyc = cyc;
        rx_a = 1'b0;
        tick(3 * 10 * BIT_CYC);
        check("break_busy", busy_a, 1'b1);
        check("break_one_entry", rise_cnt_a, n0 + 1);
        lat = rise_cyc_a - start_cyc;
        check("break_latency", lat, 3 + 53 + BIT_CYC * 9);
        pop_check(0, 8'h00, 1'b1, 1'b0, 1'b1);
        tick(200);
        check("break_no_retrigger", {valid_a, busy_a}, 2'b01);
        rx_a = 1'b1;
        tick(10);
        check("break_release_idle", busy_a, 1'b0);
        send_frame(0, 8'h5A, 1'b0, 1'b1, 11, 1'b0);
        tick(10);
        pop_check(0, 8'h5A, 1'b0, 1'b0, 1'b0);

        // Overflow: fifth character dropped with no reader.
        o0 = ovf_cnt_a;
        for (int i = 0; i < 5; i++) begin
            d = 8'h41 + 8'(i);
            send_frame(0, d, 1'b0, 1'b1, 11, 1'b0);
            tick(10);
        end
        check("ovf_pulse_once", ovf_cnt_a, o0 + 1);
        for (int i = 0; i < 4; i++) begin
            d = 8'h41 + 8'(i);
            pop_check(0, d, 1'b0, 1'b0, 1'b0);
        end
        @(negedge clk);
        check("ovf_drained", valid_a, 1'b0);

        // Full FIFO with a pop in the push cycle: no loss.
        o0 = ovf_cnt_a;
        for (int i = 0; i < 5; i++) begin
            d = 8'h41 + 8'(i);
            send_frame(0, d, 1'b0, 1'b1, 11, (i == 4));
            tick(10);
        end
        check("ovf_none_with_pop", ovf_cnt_a, o0);
        for (int i = 1; i < 5; i++) begin
            d = 8'h41 + 8'(i);
            pop_check(0, d, 1'b0, 1'b0, 1'b0);
        end
        @(negedge clk);
        check("pop_push_drained", valid_a, 1'b0);

        // Reset in the middle of a data bit, with an entry already queued.
        send_frame(0, 8'h12, 1'b0, 1'b1, 11, 1'b0);
        tick(10);
        send_frame(0, 8'h7E, 1'b0, 1'b1, 4, 1'b0);
        tick(50);
        check("pre_reset_state", {valid_a, busy_a}, 2'b11);
        resetn = 1'b0;
        #1;
        check("midframe_reset_a", {data_a, ferr_a, perr_a, brk_a, valid_a, ovf_a, busy_a}, 0);
        rx_a = 1'b1;
        tick(3);
        resetn = 1'b1;
        tick(10);
        check("post_reset_idle", {valid_a, busy_a}, 2'b00);
        n0 = rise_cnt_a;
        send_frame(0, 8'h31, 1'b0, 1'b1, 11, 1'b0);
        tick(10);
        check("post_reset_one_entry", rise_cnt_a, n0 + 1);
        pop_check(0, 8'h31, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("post_reset_drained", valid_a, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
